// File: rtl/regfile_2r1w.sv
// Register file with one write port and two independently enabled, registered read ports.
// Same-cycle write/read of one address returns the new data; entry 0 can be hardwired to zero.
module regfile_2r1w #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] Din,
  input  logic             ren_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] Dout_a,
  input  logic             ren_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] Dout_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_a_q, dout_b_q;
  logic [WIDTH-1:0] dout_a_d, dout_b_d;
  logic             wr_en;

  // Writes to the hardwired-zero entry are dropped before they reach the array.
  assign wr_en = wen && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr] <= Din;
    end
  end

  // Zero entry wins over the write-first bypass, which wins over the stored word.
  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end
    if (wen && (addr == waddr)) begin
      return Din;
    end
    return mem_q[addr];
  endfunction

  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (ren_a) begin
      dout_a_d = read_word(raddr_a);
    end
    if (ren_b) begin
      dout_b_d = read_word(raddr_b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign Dout_a = dout_a_q;
  assign Dout_b = dout_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives an 8x8 plain instance and a 32x32 zero-register instance with shared stimulus,
// comparing both against an array-based reference model after every clock edge.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] din;
  logic        ren_a, ren_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [7:0]  dout0_a, dout0_b;
  logic [31:0] dout1_a, dout1_b;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr[2:0]), .Din(din[7:0]),
    .ren_a(ren_a), .raddr_a(raddr_a[2:0]), .Dout_a(dout0_a),
    .ren_b(ren_b), .raddr_b(raddr_b[2:0]), .Dout_b(dout0_b)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .Din(din),
    .ren_a(ren_a), .raddr_a(raddr_a), .Dout_a(dout1_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .Dout_b(dout1_b)
  );

  // Reference model state
  logic [7:0]  mem0 [8];
  logic [31:0] mem1 [32];
  logic [7:0]  exp0_a, exp0_b;
  logic [31:0] exp1_a, exp1_b;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read0(input logic [4:0] addr);
    if (wen && addr[2:0] == waddr[2:0]) return din[7:0];
    return mem0[addr[2:0]];
  endfunction

  function automatic logic [31:0] model_read1(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (wen && addr == waddr) return din;
    return mem1[addr];
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 8; i++) mem0[i] = 8'd0;
      for (int i = 0; i < 32; i++) mem1[i] = 32'd0;
      exp0_a = 8'd0; exp0_b = 8'd0; exp1_a = 32'd0; exp1_b = 32'd0;
    end else begin
      if (ren_a) begin exp0_a = model_read0(raddr_a); exp1_a = model_read1(raddr_a); end
      if (ren_b) begin exp0_b = model_read0(raddr_b); exp1_b = model_read1(raddr_b); end
      if (wen) begin
        mem0[waddr[2:0]] = din[7:0];
        if (waddr != 5'd0) mem1[waddr] = din;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("dut0_a", {24'd0, dout0_a}, {24'd0, exp0_a});
    check("dut0_b", {24'd0, dout0_b}, {24'd0, exp0_b});
    check("dut1_a", dout1_a, exp1_a);
    check("dut1_b", dout1_b, exp1_b);
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] d,
                       input logic rea, input logic [4:0] ra, input logic reb, input logic [4:0] rb);
    rst = r; wen = we; waddr = wa; din = d;
    ren_a = rea; raddr_a = ra; ren_b = reb; raddr_b = rb;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem0[i] = 8'hxx;
    for (int i = 0; i < 32; i++) mem1[i] = 32'hxxxxxxxx;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Fill with 0xA5, reset, then every entry reads back zero on both ports
    for (int k = 0; k < 32; k++) drive(0, 1, 5'(k), 32'hA5A5A5A5, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 32; k++) drive(0, 0, 0, 0, 1, 5'(k), 1, 5'(k));

    // Basic write/read: A at k, B at 7-k
    for (int k = 0; k < 8; k++) drive(0, 1, 5'(k), 32'h11 * k, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 1, 5'(k), 1, 5'(7 - k));

    // Bypass on both ports, then a plain read of the same address
    drive(0, 1, 5, 32'h33, 0, 0, 0, 0);
    drive(0, 1, 5, 32'h7E, 1, 5, 1, 5);
    drive(0, 0, 0, 0, 1, 5, 0, 0);

    // Hold on disable while address and contents change
    drive(0, 1, 3, 32'h42, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 3, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 1, 3, $urandom, 0, 5'($urandom), 1, 5'($urandom));

    // Zero register: write 0xFF to 0 and 1, bypass attempt on 0
    drive(0, 1, 0, 32'hFF, 0, 0, 0, 0);
    drive(0, 1, 1, 32'hFF, 1, 0, 0, 0);
    drive(0, 1, 0, 32'hFF, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 1, 0);

    // Wide values at the extreme addresses, then a write lost to reset
    drive(0, 1, 31, 32'hDEADBEEF, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h00000001, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 31, 1, 0);
    drive(1, 1, 9, 32'hCAFEF00D, 1, 9, 1, 9);
    drive(0, 0, 0, 0, 1, 9, 1, 1);
    drive(0, 1, 9, 32'h12345678, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 9, 0, 0);

    // Randomized traffic, occasional reset
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 5'($urandom), $urandom,
            $urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
